// File: rtl/diag_stim_pkg.sv
// -----------------------------------------------------------------------------
// diag_stim_pkg
// Shared definitions for the diagnostic stimulus sequencer:
//   - mode_e  : pattern select encodings (CONST, COUNT, WALK, LFSR)
//   - state_e : sequencer FSM state encodings (IDLE, RUN, DONE)
//   - TAPS    : maximal-length Fibonacci LFSR tap masks for widths 2..32,
//               bit (n-1) set for polynomial term x^n. Compiled in only when
//               DIAG_STIM_LFSR_EN is defined.
// -----------------------------------------------------------------------------
package diag_stim_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

`ifdef DIAG_STIM_LFSR_EN
  // Index is the register width; entry holds the feedback tap mask.
  localparam logic [31:0] TAPS [2:32] = '{
    32'h0000_0003,  // 2 : x^2+x+1
    32'h0000_0006,  // 3
    32'h0000_000C,  // 4
    32'h0000_0014,  // 5
    32'h0000_0030,  // 6
    32'h0000_0060,  // 7
    32'h0000_00B8,  // 8 : x^8+x^6+x^5+x^4+1
    32'h0000_0110,  // 9
    32'h0000_0240,  // 10
    32'h0000_0500,  // 11
    32'h0000_0829,  // 12
    32'h0000_100D,  // 13
    32'h0000_2015,  // 14
    32'h0000_6000,  // 15
    32'h0000_D008,  // 16
    32'h0001_2000,  // 17
    32'h0002_0400,  // 18
    32'h0004_0023,  // 19
    32'h0009_0000,  // 20
    32'h0014_0000,  // 21
    32'h0030_0000,  // 22
    32'h0042_0000,  // 23
    32'h00E1_0000,  // 24
    32'h0120_0000,  // 25
    32'h0200_0023,  // 26
    32'h0400_0013,  // 27
    32'h0900_0000,  // 28
    32'h1400_0000,  // 29
    32'h2000_0029,  // 30
    32'h4800_0000,  // 31
    32'h8020_0003   // 32
  };
`endif

endpackage

// File: rtl/diag_stim_chan.sv
// -----------------------------------------------------------------------------
// diag_stim_chan
// Purely combinational per-channel view of the shared base value: the base is
// rotated left by (INDEX mod WIDTH) bits, so channel 0 carries the base itself.
// Ports:
//   base  in  WIDTH  current base value b(k)
//   stim  out WIDTH  rotated channel value
// -----------------------------------------------------------------------------
module diag_stim_chan #(
  parameter int WIDTH = 8,
  parameter int INDEX = 0
) (
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] stim
);

  localparam int SHIFT = INDEX % WIDTH;

  // A zero rotate is split out so no slice ever has reversed bounds.
  if (SHIFT == 0) begin : g_pass
    assign stim = base;
  end else begin : g_rot
    assign stim = {base[WIDTH-1-SHIFT:0], base[WIDTH-1:WIDTH-SHIFT]};
  end

endmodule

// File: rtl/diag_stim_seq.sv
// -----------------------------------------------------------------------------
// diag_stim_seq
// Stimulus sequencer for diagnostic benches. A start pulse latches mode/seed
// and runs for RUN_CYCLES cycles producing per-channel patterns (CONST, COUNT,
// WALK, LFSR), then parks in DONE holding the last value until restarted.
// Configuration macro: DIAG_STIM_LFSR_EN -- when undefined, no LFSR logic is
// built and mode 3 behaves as CONST.
// Ports:
//   clock      in  1                     rising-edge clock
//   reset      in  1                     synchronous active-high reset
//   start      in  1                     run request (honoured in IDLE/DONE)
//   mode       in  2                     pattern select (diag_stim_pkg::mode_e)
//   seed       in  WIDTH                 initial base value
//   stim       out CHANNELS*WIDTH        channel i at [i*WIDTH +: WIDTH]
//   active     out 1                     high while in RUN
//   done       out 1                     high while in DONE
//   cycle_cnt  out $clog2(RUN_CYCLES+1)  current RUN cycle index k
// -----------------------------------------------------------------------------
module diag_stim_seq
  import diag_stim_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int RUN_CYCLES = 10
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [WIDTH-1:0]                  seed,
  output logic [CHANNELS*WIDTH-1:0]         stim,
  output logic                              active,
  output logic                              done,
  output logic [$clog2(RUN_CYCLES+1)-1:0]   cycle_cnt
);

  localparam int                CNT_W = $clog2(RUN_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(RUN_CYCLES - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("diag_stim_seq: WIDTH must be within 2..32");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("diag_stim_seq: CHANNELS must be at least 1");
  end
  if (RUN_CYCLES < 1) begin : g_bad_run
    $error("diag_stim_seq: RUN_CYCLES must be at least 1");
  end

`ifdef DIAG_STIM_LFSR_EN
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH][WIDTH-1:0];
`endif

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [WIDTH-1:0]  base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              launch;
  logic              advance;
  logic [WIDTH-1:0]  base_init;
  logic [WIDTH-1:0]  base_step;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; without it any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          launch  = 1'b1;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here.
        if (cnt_q == LAST) state_d = ST_DONE;
        else               advance = 1'b1;
      end
      ST_DONE: begin
        // Restart goes straight to RUN with no idle gap.
        if (start) begin
          state_d = ST_RUN;
          launch  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active    = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cycle_cnt = cnt_q;

  // ---------------------------------------------------------------------------
  // Base value generation
  // ---------------------------------------------------------------------------
  // b(0) from the live mode/seed inputs, sampled only on the launch edge.
  always_comb begin
    base_init = seed;
    case (mode_e'(mode))
      MODE_WALK: base_init = WIDTH'(1);
`ifdef DIAG_STIM_LFSR_EN
      // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
      MODE_LFSR: base_init = (seed == '0) ? WIDTH'(1) : seed;
`endif
      default:   base_init = seed;
    endcase
  end

  // b(k+1) from b(k) under the latched mode. WALK is a rotate by one, which
  // equals 1 << (k mod WIDTH) since it starts from 1.
  always_comb begin
    base_step = base_q;
    case (mode_q)
      MODE_COUNT: base_step = base_q + WIDTH'(1);
      MODE_WALK:  base_step = {base_q[WIDTH-2:0], base_q[WIDTH-1]};
`ifdef DIAG_STIM_LFSR_EN
      MODE_LFSR:  base_step = {base_q[WIDTH-2:0], ^(base_q & TAP_MASK)};
`endif
      default:    base_step = base_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= MODE_CONST;
      base_q <= '0;
      cnt_q  <= '0;
    end else if (launch) begin
      mode_q <= mode_e'(mode);
      base_q <= base_init;
      cnt_q  <= '0;
    end else if (advance) begin
      base_q <= base_step;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel fan-out
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    diag_stim_chan #(
      .WIDTH (WIDTH),
      .INDEX (i)
    ) u_chan (
      .base (base_q),
      .stim (stim[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_diag_stim_seq.sv
// -----------------------------------------------------------------------------
// tb_diag_stim_seq
// Self-checking bench for diag_stim_seq. One instance uses the default
// parameters (WIDTH=8, CHANNELS=2, RUN_CYCLES=10); a second uses RUN_CYCLES=1.
// Expected values come from hand-computed vectors and from a reference model
// that evaluates b(k) directly from its closed-form definition.
// Honours DIAG_STIM_LFSR_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_diag_stim_seq;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int RC = 10;
  localparam int CW = $clog2(RC + 1);

  logic            clock = 1'b0;
  logic            reset, start, reset1, start1;
  logic [1:0]      mode;
  logic [W-1:0]    seed;
  logic [CH*W-1:0] stim, stim1;
  logic            active, done, active1, done1;
  logic [CW-1:0]   cycle_cnt;
  logic [0:0]      cycle_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  diag_stim_seq #(.WIDTH(W), .CHANNELS(CH), .RUN_CYCLES(RC)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .stim      (stim),
    .active    (active),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  diag_stim_seq #(.WIDTH(W), .CHANNELS(CH), .RUN_CYCLES(1)) dut1 (
    .clock     (clock),
    .reset     (reset1),
    .start     (start1),
    .mode      (mode),
    .seed      (seed),
    .stim      (stim1),
    .active    (active1),
    .done      (done1),
    .cycle_cnt (cycle_cnt1)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] seed;
    int         k;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] s);
    mode  = m;
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: rotate left by n, built bit by bit.
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    for (int j = 0; j < W; j++) r[(j + n) % W] = b[j];
    return r;
  endfunction

  // Reference: b(k) straight from the pattern definitions.
  function automatic logic [7:0] exp_base(input logic [1:0] m, input logic [7:0] s, input int k);
    logic [7:0] v;
    case (m)
      2'd1:    v = 8'((int'(s) + k) % 256);
      2'd2:    v = 8'(1 << (k % W));
`ifdef DIAG_STIM_LFSR_EN
      2'd3: begin
        v = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < k; i++) v = {v[6:0], ^(v & 8'hB8)};
      end
`endif
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic logic [CH*W-1:0] exp_stim(input logic [1:0] m, input logic [7:0] s, input int k);
    logic [CH*W-1:0] r;
    logic [7:0]      b;
    b = exp_base(m, s, k);
    for (int i = 0; i < CH; i++) r[i*W +: W] = rotl(b, i % W);
    return r;
  endfunction

  logic [1:0] rm;
  logic [7:0] rs;
  int         n_act;
  int         first_done;

  initial begin
    reset  = 1'b1;
    reset1 = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 2'd0;
    seed   = 8'h00;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_stim",   32'(stim),      32'h0);
    check("rst_active", 32'(active),    32'h0);
    check("rst_done",   32'(done),      32'h0);
    check("rst_cnt",    32'(cycle_cnt), 32'h0);
    check("rst1_done",  32'(done1),     32'h0);
    reset  = 1'b0;
    reset1 = 1'b0;
    tick();
    check("idle_active", 32'(active), 32'h0);

    // ---------------- table-driven vectors ----------------
    vec.push_back('{2'd1, 8'hFE, 0, 8'hFE, 8'hFD});
    vec.push_back('{2'd1, 8'hFE, 1, 8'hFF, 8'hFF});
    vec.push_back('{2'd1, 8'hFE, 2, 8'h00, 8'h00});
    vec.push_back('{2'd1, 8'hFE, 3, 8'h01, 8'h02});
    vec.push_back('{2'd1, 8'hFE, 9, 8'h07, 8'h0E});
    vec.push_back('{2'd2, 8'h55, 0, 8'h01, 8'h02});
    vec.push_back('{2'd2, 8'h55, 7, 8'h80, 8'h01});
    vec.push_back('{2'd2, 8'h55, 8, 8'h01, 8'h02});
    vec.push_back('{2'd2, 8'h55, 9, 8'h02, 8'h04});
    vec.push_back('{2'd0, 8'hA5, 0, 8'hA5, 8'h4B});
    vec.push_back('{2'd0, 8'hA5, 9, 8'hA5, 8'h4B});
`ifdef DIAG_STIM_LFSR_EN
    vec.push_back('{2'd3, 8'h00, 0, 8'h01, 8'h02});
    vec.push_back('{2'd3, 8'h00, 1, 8'h02, 8'h04});
    vec.push_back('{2'd3, 8'h00, 3, 8'h08, 8'h10});
    vec.push_back('{2'd3, 8'h00, 4, 8'h11, 8'h22});
    vec.push_back('{2'd3, 8'h00, 5, 8'h23, 8'h46});
`else
    vec.push_back('{2'd3, 8'h00, 0, 8'h00, 8'h00});
    vec.push_back('{2'd3, 8'h00, 5, 8'h00, 8'h00});
    vec.push_back('{2'd3, 8'h3C, 9, 8'h3C, 8'h78});
`endif

    foreach (vec[r]) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      launch(vec[r].mode, vec[r].seed);
      repeat (vec[r].k) tick();
      check($sformatf("vec%0d_ch0", r), 32'(stim[7:0]),  32'(vec[r].e0));
      check($sformatf("vec%0d_ch1", r), 32'(stim[15:8]), 32'(vec[r].e1));
      check($sformatf("vec%0d_cnt", r), 32'(cycle_cnt),  32'(vec[r].k));
    end

    // ---------------- reset at k=5 ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    launch(2'd1, 8'hFE);
    repeat (5) tick();
    check("midrst_pre_cnt", 32'(cycle_cnt), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_stim",   32'(stim),      32'h0);
    check("midrst_active", 32'(active),    32'h0);
    check("midrst_done",   32'(done),      32'h0);
    check("midrst_cnt",    32'(cycle_cnt), 32'h0);
    tick();
    check("midrst_idle", 32'(active | done), 32'h0);

    // ---------------- CONST run with ignored start at k=4 ----------------
    launch(2'd0, 8'hA5);
    n_act      = 0;
    first_done = -1;
    for (int c = 0; c < 15; c++) begin
      if (active) n_act++;
      if (done && first_done < 0) first_done = c;
      if (c == 4) begin
        mode  = 2'd2;
        seed  = 8'h00;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check("const_active_len", 32'(n_act),      32'd10);
    check("const_done_at",    32'(first_done), 32'd10);
    check("const_stim_hold",  32'(stim),       32'h4BA5);
    check("const_cnt_hold",   32'(cycle_cnt),  32'd9);

    // ---------------- restart from DONE, no gap ----------------
    launch(2'd1, 8'h10);
    check("restart_active", 32'(active),    32'h1);
    check("restart_done",   32'(done),      32'h0);
    check("restart_cnt",    32'(cycle_cnt), 32'h0);
    check("restart_stim",   32'(stim),      32'h2010);

    // ---------------- RUN_CYCLES = 1 ----------------
    mode   = 2'd1;
    seed   = 8'h03;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("rc1_active", 32'(active1),    32'h1);
    check("rc1_done",   32'(done1),      32'h0);
    check("rc1_cnt",    32'(cycle_cnt1), 32'h0);
    check("rc1_stim",   32'(stim1),      32'h0603);
    tick();
    check("rc1_done_a", 32'({active1, done1}), 32'b01);
    check("rc1_hold",   32'(stim1),            32'h0603);
    mode   = 2'd0;
    seed   = 8'h81;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("rc1_re_state", 32'({active1, done1}), 32'b10);
    check("rc1_re_stim",  32'(stim1),            32'h0381);
    tick();
    check("rc1_re_done",  32'({active1, done1}), 32'b01);

    // ---------------- randomized runs vs reference model ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int run = 0; run < 40; run++) begin
      rm = 2'($urandom_range(0, 3));
      rs = 8'($urandom);
      launch(rm, rs);
      for (int k = 0; k < RC; k++) begin
        check("rnd_stim",   32'(stim),           32'(exp_stim(rm, rs, k)));
        check("rnd_state",  32'({active, done}), 32'b10);
        check("rnd_cnt",    32'(cycle_cnt),      32'(k));
        if ($urandom_range(0, 3) == 0) begin
          mode  = 2'($urandom_range(0, 3));
          seed  = 8'($urandom);
          start = 1'b1;
        end
        tick();
        start = 1'b0;
      end
      check("rnd_done_state", 32'({active, done}), 32'b01);
      check("rnd_done_stim",  32'(stim),           32'(exp_stim(rm, rs, RC - 1)));
      check("rnd_done_cnt",   32'(cycle_cnt),      32'(RC - 1));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("rnd_hold_stim", 32'(stim), 32'(exp_stim(rm, rs, RC - 1)));
      end
      if ($urandom_range(0, 2) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rnd_rst_stim", 32'(stim), 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diag_stim_seq.md
# diag_stim_seq

Parametrised stimulus sequencer for the diagnostic regression benches. It replaces the single constant tie-off that drives a device instance with per-channel stimulus: constant, counting, walking-one or LFSR patterns. It runs for a fixed number of clock cycles, then signals completion so the bench top can stop dumping and call `$finish`. It sits between the bench's `main` module and the device instances, and it is synthesizable so the diags exercise real sequential coverage.

## Interface
- `WIDTH`, 8: bits per channel; 2..32.
- `CHANNELS`, 2: number of stimulus channels; >=1.
- `RUN_CYCLES`, 10: cycles spent in RUN per start; >=1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run.
- `mode`  in  2  pattern select: 0 CONST, 1 COUNT, 2 WALK, 3 LFSR.
- `seed`  in  WIDTH  initial base value.
- `stim`  out  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `active`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `cycle_cnt`  out  $clog2(RUN_CYCLES+1)  index k of the current RUN cycle.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE with `start`=1: go to RUN. `mode` and `seed` are latched on this edge and ignored afterwards.
- RUN: k counts 0..RUN_CYCLES-1. After the cycle with k = RUN_CYCLES-1, go to DONE.
- `start` in RUN is ignored.
- DONE: hold outputs. `start`=1 restarts a run (RUN, k=0, re-latch `mode` and `seed`).
- Base value b(k):
  - CONST: b = seed.
  - COUNT: b = seed + k, mod 2^WIDTH.
  - WALK: b = 1 << (k mod WIDTH). The seed is ignored.
  - LFSR: b(0) = seed, with seed 0 replaced by 1. b(k+1) = {b[WIDTH-2:0], ^(b & TAPS[WIDTH])}.
- Channel i output is b rotated left by (i mod WIDTH) bits. Channel 0 is b itself.
- Arithmetic wraps silently. There are no overflow flags.

## Timing
- Reset values: `stim`=0, `active`=0, `done`=0, `cycle_cnt`=0, state IDLE.
- Reset wins over `start` in the same cycle.
- Reset mid-run returns the block to reset values on the next edge. No partial completion is reported.
- Edge after `start`: `active`=1, `cycle_cnt`=0, `stim`=channel values of b(0). Latency is one cycle.
- Each subsequent edge in RUN advances k, `cycle_cnt` and `stim` together.
- `active` is high for exactly RUN_CYCLES cycles.
- On the edge that enters DONE: `active`=0, `done`=1. `stim` keeps b(RUN_CYCLES-1) and `cycle_cnt` keeps RUN_CYCLES-1.
- `start` in DONE: on the next edge `done`=0, `active`=1, k=0. There is no idle gap.
- RUN_CYCLES=1: RUN lasts one cycle, and DONE follows on the next edge.

## Configuration
- `DIAG_STIM_LFSR_EN` defined: LFSR mode and the taps table are compiled in.
- `DIAG_STIM_LFSR_EN` undefined: no LFSR logic. Mode 3 behaves exactly as CONST.

## Structure
- Package `diag_stim_pkg` holds:
  - the mode encodings `MODE_CONST`, `MODE_COUNT`, `MODE_WALK`, `MODE_LFSR`;
  - the FSM state encodings;
  - the `TAPS` table for widths 2..32, maximal-length polynomials, e.g. 8 → 8'hB8.
- An unsupported `WIDTH` is an elaboration error.
- Sub-module `diag_stim_chan`: a combinational rotate of b by a constant channel index, instantiated CHANNELS times in a generate loop.
- The FSM, counter and base-value register live in the top.

## Test plan
- COUNT, seed 8'hFE, defaults:
  - channel 0 runs FE, FF, 00, 01, …; channel 1 runs FD, FF, 00, 02, ….
  - `active` is high for 10 cycles, then `done`=1 with channel 0 holding 07.
- WALK, seed 8'h55: channel 0 runs 01, 02, 04 … 80, 01, 02. Wraparound occurs at k=8.
- CONST, seed 8'hA5, `start` pulsed again at k=4: pulse ignored; `stim` stays A5/4B; `done` rises after exactly 10 cycles.
- LFSR with macro defined, seed 0: b(0)=01, b(1)=02, …, matching the reference polynomial 8'hB8. Same stimulus with macro undefined: `stim` constant at 00/00.
- Reset asserted at k=5: next edge all outputs are 0 and state is IDLE. A following `start` completes a full 10-cycle run.
- RUN_CYCLES=1, `start` while in DONE: `active` is high for exactly one cycle and `done` re-asserts on the following edge.
